// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master.
package spi_pkg;
  localparam int SPI_BITS        = 8;
  localparam int SPI_CLK_DIV_MIN = 2;

  typedef enum logic [2:0] {
    IDLE, SETUP, HIGH, LOW, TAIL, GUARD, WAIT
  } spi_state_t;
endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider: phase_end ticks on the last clk of each CLK_DIV-cycle phase.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase_end
);
  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       last;

  assign last      = (cnt_q == LAST);
  assign phase_end = en && last;

  // Disabled means held at zero, so enabling it restarts a full phase.
  always_comb begin
    cnt_d = 8'd0;
    if (en && !last) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 8'd0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/spi_master.sv
// Mode-0, MSB-first byte SPI master. Define SPI_MASTER_BURST_EN to keep ss
// low between bytes when hold is set.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       hold,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sck,
  output logic       ss,
  output logic       mosi,
  input  logic       miso
);
  if (CLK_DIV < SPI_CLK_DIV_MIN) begin : g_bad_div
    $error("spi_master: CLK_DIV must be >= 2");
  end

  spi_state_t          state_q;
  logic [SPI_BITS-1:0] tx_q, rx_sh_q, rx_q;
  logic [2:0]          bit_q;
  logic                sck_q, ss_q, mosi_q, busy_q, done_q;
  logic                div_en, pe;

  assign div_en = (state_q != IDLE) && (state_q != WAIT);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk(clk), .rst(rst), .en(div_en), .phase_end(pe)
  );

`ifdef SPI_MASTER_BURST_EN
  logic hold_q;
`else
  logic unused_hold;
  assign unused_hold = hold;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      bit_q   <= 3'd0;
      sck_q   <= 1'b0;
      ss_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
      hold_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          tx_q    <= tx_data;
          mosi_q  <= tx_data[7];
          ss_q    <= 1'b0;
          busy_q  <= 1'b1;
`ifdef SPI_MASTER_BURST_EN
          hold_q  <= hold;
`endif
          state_q <= SETUP;
        end
        SETUP, LOW: if (pe) begin
          sck_q   <= 1'b1;
          state_q <= HIGH;
        end
        HIGH: if (pe) begin
          sck_q   <= 1'b0;
          rx_sh_q <= {rx_sh_q[SPI_BITS-2:0], miso};
          bit_q   <= bit_q + 3'd1;
          if (bit_q == 3'd7) state_q <= TAIL;
          else begin
            mosi_q  <= tx_q[SPI_BITS-2];
            tx_q    <= {tx_q[SPI_BITS-2:0], 1'b0};
            state_q <= LOW;
          end
        end
        TAIL: if (pe) begin
          done_q <= 1'b1;
          rx_q   <= rx_sh_q;
          mosi_q <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
          if (hold_q) begin
            busy_q  <= 1'b0;
            state_q <= WAIT;
          end else
`endif
          begin
            ss_q    <= 1'b1;
            state_q <= GUARD;
          end
        end
        GUARD: if (pe) begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
`ifdef SPI_MASTER_BURST_EN
        // ss stays low here; the next byte starts without a guard interval.
        WAIT: if (start) begin
          tx_q    <= tx_data;
          mosi_q  <= tx_data[7];
          hold_q  <= hold;
          busy_q  <= 1'b1;
          state_q <= SETUP;
        end else if (!hold) begin
          ss_q    <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= GUARD;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sck     = sck_q;
  assign ss      = ss_q;
  assign mosi    = mosi_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_q;
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master (CLK_DIV=2) with a behavioural mode-0 slave.
module tb_spi_master;
  localparam int CD = 2;

  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, hold = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       busy, done, sck, ss, mosi;
  logic [7:0] rx_data;
  logic       miso = 1'b0;

  spi_master #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .hold(hold),
    .busy(busy), .done(done), .rx_data(rx_data),
    .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] tx; logic [7:0] rx; } exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0;
  int cyc = 0, t0 = 0, ndone = 0, rises = 0, ssr = 0;
  logic [15:0] mosi_cap = '0;

  always @(posedge clk) cyc++;
  always @(posedge clk) if (done) ndone++;
  always @(posedge sck) begin rises++; mosi_cap = {mosi_cap[14:0], mosi}; end
  always @(posedge ss) ssr++;

  // Slave model: loads dout on ss fall and every 8 bits, samples on sck rise.
  logic [7:0] slv_dout = 8'h00, slv_din = 8'h00, sreg = 8'h00;
  int   sbits = 0;
  logic ss_prev = 1'b1, sck_prev = 1'b0;
  always @(ss or sck) begin
    if (ss) miso = 1'b0;
    else if (ss_prev) begin sreg = slv_dout; sbits = 0; miso = sreg[7]; end
    else if (sck && !sck_prev) begin slv_din = {slv_din[6:0], mosi}; sbits++; end
    else if (!sck && sck_prev) begin
      if (sbits == 8) begin sreg = slv_dout; sbits = 0; end
      else sreg = {sreg[6:0], 1'b0};
      miso = sreg[7];
    end
    ss_prev = ss; sck_prev = sck;
  end

  task automatic start_xfer(input logic [7:0] tx, input logic [7:0] rx, input logic hld);
    @(negedge clk);
    sb.push_back('{tx: tx, rx: rx});
    start = 1'b1; tx_data = tx; hold = hld;
    @(negedge clk);
    start = 1'b0; t0 = cyc;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks += 6;
    if (ss !== 1'b1)       begin failures++; $display("FAIL reset_ss got=%b exp=1", ss); end
    if (sck !== 1'b0)      begin failures++; $display("FAIL reset_sck got=%b exp=0", sck); end
    if (mosi !== 1'b0)     begin failures++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
    if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx got=%h exp=00", rx_data); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    bit ok; int r0; exp_t e;
    slv_dout = 8'h3C; r0 = rises;
    start_xfer(8'hA5, 8'h3C, 1'b0);
    checks += 2;
    if (ss !== 1'b0)   begin failures++; $display("FAIL single_ss_fall got=%b exp=0", ss); end
    if (mosi !== 1'b1) begin failures++; $display("FAIL single_mosi0 got=%b exp=1", mosi); end
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_done timeout got=0 exp=1"); return; end
    e = sb.pop_front();
    checks += 5;
    if (rx_data !== e.rx)        begin failures++; $display("FAIL single_rx got=%h exp=%h", rx_data, e.rx); end
    if (mosi_cap[7:0] !== e.tx)  begin failures++; $display("FAIL single_mosi got=%h exp=%h", mosi_cap[7:0], e.tx); end
    if (cyc - t0 != 34)          begin failures++; $display("FAIL single_lat got=%0d exp=34", cyc - t0); end
    if (rises - r0 != 8)         begin failures++; $display("FAIL single_rises got=%0d exp=8", rises - r0); end
    if (ss !== 1'b1)             begin failures++; $display("FAIL single_ss_rise got=%b exp=1", ss); end
    @(negedge clk);
    checks += 2;
    if (done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%b exp=0", done); end
    if (busy !== 1'b1) begin failures++; $display("FAIL single_guard got=%b exp=1", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_fall got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    bit ok, idle; int ta; exp_t e;
    slv_dout = 8'h81;
    start_xfer(8'h0F, 8'h81, 1'b0);
    ta = t0;
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_done1 timeout got=0 exp=1"); return; end
    e = sb.pop_front();
    checks++;
    if (rx_data !== e.rx) begin failures++; $display("FAIL b2b_rx1 got=%h exp=%h", rx_data, e.rx); end
    slv_dout = 8'hE7;
    sb.push_back('{tx: 8'hF0, rx: 8'hE7});
    start = 1'b1; tx_data = 8'hF0;
    idle = 1'b0;
    for (int i = 0; i < 10 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    @(negedge clk);
    start = 1'b0; t0 = cyc;
    checks += 3;
    if (!idle)        begin failures++; $display("FAIL b2b_idle got=0 exp=1"); end
    if (t0 - ta != 37) begin failures++; $display("FAIL b2b_accept got=%0d exp=37", t0 - ta); end
    if (ss !== 1'b0)  begin failures++; $display("FAIL b2b_ss got=%b exp=0", ss); end
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_done2 timeout got=0 exp=1"); return; end
    e = sb.pop_front();
    checks += 2;
    if (rx_data !== e.rx)       begin failures++; $display("FAIL b2b_rx2 got=%h exp=%h", rx_data, e.rx); end
    if (mosi_cap[7:0] !== e.tx) begin failures++; $display("FAIL b2b_mosi2 got=%h exp=%h", mosi_cap[7:0], e.tx); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_loopback;
    bit ok; exp_t e;
    slv_dout = 8'h5A;
    start_xfer(8'hC3, 8'h5A, 1'b0);
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL loop_done timeout got=0 exp=1"); return; end
    e = sb.pop_front();
    checks += 2;
    if (slv_din !== e.tx) begin failures++; $display("FAIL loop_din got=%h exp=%h", slv_din, e.tx); end
    if (rx_data !== e.rx) begin failures++; $display("FAIL loop_rx got=%h exp=%h", rx_data, e.rx); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit ok; int r0, d0; exp_t e;
    slv_dout = 8'h66; r0 = rises;
    start_xfer(8'h99, 8'h66, 1'b0);
    for (int i = 0; i < 100 && rises - r0 < 4; i++) @(negedge clk);
    checks++;
    if (rises - r0 != 4) begin failures++; $display("FAIL rmid_rises got=%0d exp=4", rises - r0); end
    void'(sb.pop_back());
    d0 = ndone;
    #1 rst = 1'b0;
    #1;
    checks += 3;
    if (ss !== 1'b1)   begin failures++; $display("FAIL rmid_ss got=%b exp=1", ss); end
    if (sck !== 1'b0)  begin failures++; $display("FAIL rmid_sck got=%b exp=0", sck); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (ndone != d0) begin failures++; $display("FAIL rmid_nodone got=%0d exp=%0d", ndone, d0); end
    slv_dout = 8'h24;
    start_xfer(8'h42, 8'h24, 1'b0);
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rmid_done timeout got=0 exp=1"); return; end
    e = sb.pop_front();
    checks += 2;
    if (rx_data !== e.rx)       begin failures++; $display("FAIL rmid_rx got=%h exp=%h", rx_data, e.rx); end
    if (mosi_cap[7:0] !== e.tx) begin failures++; $display("FAIL rmid_mosi got=%h exp=%h", mosi_cap[7:0], e.tx); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_start_busy;
    bit ok; int d0; exp_t e;
    slv_dout = 8'h69; d0 = ndone;
    start_xfer(8'h96, 8'h69, 1'b0);
    repeat (6) @(negedge clk);
    start = 1'b1; tx_data = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL sbusy_done timeout got=0 exp=1"); return; end
    e = sb.pop_front();
    checks += 2;
    if (rx_data !== e.rx)       begin failures++; $display("FAIL sbusy_rx got=%h exp=%h", rx_data, e.rx); end
    if (mosi_cap[7:0] !== e.tx) begin failures++; $display("FAIL sbusy_mosi got=%h exp=%h", mosi_cap[7:0], e.tx); end
    repeat (40) @(negedge clk);
    checks += 3;
    if (ndone - d0 != 1)   begin failures++; $display("FAIL sbusy_ndone got=%0d exp=1", ndone - d0); end
    if (busy !== 1'b0)     begin failures++; $display("FAIL sbusy_idle got=%b exp=0", busy); end
    if (rx_data !== e.rx)  begin failures++; $display("FAIL sbusy_rx_hold got=%h exp=%h", rx_data, e.rx); end
  endtask

`ifdef SPI_MASTER_BURST_EN
  task automatic test_burst;
    bit ok; int r0, s0, d0; exp_t e;
    slv_dout = 8'hAA; r0 = rises; s0 = ssr; d0 = ndone;
    start_xfer(8'h11, 8'hAA, 1'b1);
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL burst_done1 timeout got=0 exp=1"); return; end
    e = sb.pop_front();
    checks += 4;
    if (rx_data !== e.rx)       begin failures++; $display("FAIL burst_rx1 got=%h exp=%h", rx_data, e.rx); end
    if (mosi_cap[7:0] !== e.tx) begin failures++; $display("FAIL burst_mosi1 got=%h exp=%h", mosi_cap[7:0], e.tx); end
    if (ss !== 1'b0)            begin failures++; $display("FAIL burst_ss_held got=%b exp=0", ss); end
    if (busy !== 1'b0)          begin failures++; $display("FAIL burst_wait_busy got=%b exp=0", busy); end
    start_xfer(8'h22, 8'hAA, 1'b0);
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL burst_done2 timeout got=0 exp=1"); return; end
    e = sb.pop_front();
    checks += 5;
    if (rx_data !== e.rx)       begin failures++; $display("FAIL burst_rx2 got=%h exp=%h", rx_data, e.rx); end
    if (mosi_cap[7:0] !== e.tx) begin failures++; $display("FAIL burst_mosi2 got=%h exp=%h", mosi_cap[7:0], e.tx); end
    if (rises - r0 != 16)       begin failures++; $display("FAIL burst_rises got=%0d exp=16", rises - r0); end
    if (ssr - s0 != 1)          begin failures++; $display("FAIL burst_ss_rises got=%0d exp=1", ssr - s0); end
    if (ndone - d0 != 2)        begin failures++; $display("FAIL burst_ndone got=%0d exp=2", ndone - d0); end
    repeat (6) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_loopback();
    test_reset_mid();
    test_start_busy();
`ifdef SPI_MASTER_BURST_EN
    test_burst();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
